// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two requesters, each with a one-word holding buffer, share one UART TX strobe port.
// Build option UART_ARB_RR_EN selects round-robin on contention; otherwise req0 has fixed priority.
module uart_tx_arb #(
  parameter int DW       = 16,
  parameter int ACK_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_req0_data,
  input  logic          i_req0_valid,
  output logic          o_req0_ready,
  input  logic [DW-1:0] i_req1_data,
  input  logic          i_req1_valid,
  output logic          o_req1_ready,
  input  logic          i_tx_busy,
  output logic [DW-1:0] o_tx_data,
  output logic          o_tx_stb,
  output logic [1:0]    o_grant,
  output logic [7:0]    o_drop_cnt,
  output logic          o_timeout
);

  localparam int            CW      = $clog2(ACK_WAIT + 1);
  localparam logic [CW-1:0] ACK_LIM = CW'(ACK_WAIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STB     = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] buf0_r, buf0_s, buf1_r, buf1_s;
  logic [DW-1:0] data_r, data_s;
  logic          ready0_r, ready0_s, ready1_r, ready1_s;
  logic          stb_r, stb_s;
  logic          timeout_r, timeout_s;
  logic [1:0]    grant_r, grant_s;
  logic [7:0]    drop_r, drop_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          rel0_s, rel1_s;
  logic          pick0_s, issue_s;
  logic          drop0_s, drop1_s;
  logic [8:0]    drop_sum_s;
`ifdef UART_ARB_RR_EN
  logic          rr_last1_r;
`endif

  // Winner selection: a ready flag of 0 means that buffer holds a word.
  always_comb begin
    pick0_s = ~ready0_r;
    if (~ready0_r && ~ready1_r) begin
`ifdef UART_ARB_RR_EN
      pick0_s = rr_last1_r;
`else
      pick0_s = 1'b1;
`endif
    end else begin
      pick0_s = ~ready0_r;
    end
    issue_s = (state_r == IDLE) && (~ready0_r || ~ready1_r) && ~i_tx_busy;
  end

  // Issue/acknowledge sequencing and release of the in-flight buffer.
  always_comb begin
    state_s   = state_r;
    stb_s     = stb_r;
    data_s    = data_r;
    grant_s   = grant_r;
    cnt_s     = cnt_r;
    timeout_s = timeout_r;
    rel0_s    = 1'b0;
    rel1_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          data_s  = pick0_s ? buf0_r : buf1_r;
          grant_s = pick0_s ? 2'b01 : 2'b10;
          stb_s   = 1'b1;
          state_s = STB;
        end else begin
          state_s = IDLE;
        end
      end
      STB: begin
        stb_s   = 1'b0;
        cnt_s   = '0;
        state_s = WAIT_HI;
      end
      WAIT_HI: begin
        if (i_tx_busy) begin
          state_s = WAIT_LO;
        end else if ((cnt_r + CNT_ONE) == ACK_LIM) begin
          cnt_s     = cnt_r + CNT_ONE;
          timeout_s = 1'b1;
          rel0_s    = grant_r[0];
          rel1_s    = grant_r[1];
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (!i_tx_busy) begin
          rel0_s  = grant_r[0];
          rel1_s  = grant_r[1];
          state_s = IDLE;
        end else begin
          state_s = WAIT_LO;
        end
      end
      default: begin
        state_s = IDLE;
        stb_s   = 1'b0;
      end
    endcase
  end

  // Holding buffers and the saturating drop counter.
  always_comb begin
    drop0_s  = i_req0_valid & ~ready0_r;
    drop1_s  = i_req1_valid & ~ready1_r;
    buf0_s   = buf0_r;
    buf1_s   = buf1_r;
    ready0_s = ready0_r;
    ready1_s = ready1_r;
    if (rel0_s) begin
      ready0_s = 1'b1;
    end else if (i_req0_valid && ready0_r) begin
      ready0_s = 1'b0;
      buf0_s   = i_req0_data;
    end else begin
      ready0_s = ready0_r;
    end
    if (rel1_s) begin
      ready1_s = 1'b1;
    end else if (i_req1_valid && ready1_r) begin
      ready1_s = 1'b0;
      buf1_s   = i_req1_data;
    end else begin
      ready1_s = ready1_r;
    end
    drop_sum_s = {1'b0, drop_r} + {8'd0, drop0_s} + {8'd0, drop1_s};
    if (drop_sum_s > 9'd255) begin
      drop_s = 8'hFF;
    end else begin
      drop_s = drop_sum_s[7:0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      buf0_r    <= '0;
      buf1_r    <= '0;
      ready0_r  <= 1'b1;
      ready1_r  <= 1'b1;
      data_r    <= '0;
      stb_r     <= 1'b0;
      grant_r   <= 2'b00;
      drop_r    <= 8'd0;
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      buf0_r    <= buf0_s;
      buf1_r    <= buf1_s;
      ready0_r  <= ready0_s;
      ready1_r  <= ready1_s;
      data_r    <= data_s;
      stb_r     <= stb_s;
      grant_r   <= grant_s;
      drop_r    <= drop_s;
      cnt_r     <= cnt_s;
      timeout_r <= timeout_s;
    end
  end

`ifdef UART_ARB_RR_EN
  // Round-robin pointer: remembers whether req1 was the last one issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last1_r <= 1'b1;
    end else if (issue_s) begin
      rr_last1_r <= ~pick0_s;
    end else begin
      rr_last1_r <= rr_last1_r;
    end
  end
`endif

  assign o_req0_ready = ready0_r;
  assign o_req1_ready = ready1_r;
  assign o_tx_data    = data_r;
  assign o_tx_stb     = stb_r;
  assign o_grant      = grant_r;
  assign o_drop_cnt   = drop_r;
  assign o_timeout    = timeout_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: expected words queued at stimulus time, checked on each strobe.
module tb_uart_tx_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req0_data = 16'h0000;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [15:0] req1_data = 16'h0000;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic        tx_busy = 1'b0;
  logic [15:0] tx_data;
  logic        tx_stb;
  logic [1:0]  grant;
  logic [7:0]  drop_cnt;
  logic        timeout;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic        prev_stb = 1'b0;

  uart_tx_arb #(.DW(16), .ACK_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req0_data(req0_data), .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req1_data(req1_data), .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_tx_busy(tx_busy), .o_tx_data(tx_data), .o_tx_stb(tx_stb),
    .o_grant(grant), .o_drop_cnt(drop_cnt), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Strobe monitor: each strobe must carry the oldest expected word and last one cycle.
  always @(negedge clk) begin
    if (tx_stb) begin
      check_eq("stb_width", {31'd0, prev_stb}, 32'd0);
      if (exp_q.size() == 0) check_eq("stb_unexpected", 32'd1, 32'd0);
      else check_eq("tx_data", {16'd0, tx_data}, {16'd0, exp_q.pop_front()});
    end
    prev_stb = tx_stb;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(input int budget);
    int n = 0;
    while (!tx_stb && n < budget) begin
      tick();
      n++;
    end
    if (!tx_stb) check_eq("stb_wait_expired", 32'd0, 32'd1);
  endtask

  // Called just after the strobe is visible; models the UART busy pulse.
  task automatic xfer(input int rise, input int dur);
    repeat (rise) tick();
    tx_busy = 1'b1;
    repeat (dur) tick();
    tx_busy = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_ready0", {31'd0, req0_ready}, 32'd1);
    check_eq("rst_ready1", {31'd0, req1_ready}, 32'd1);
    check_eq("rst_stb", {31'd0, tx_stb}, 32'd0);
    check_eq("rst_grant", {30'd0, grant}, 32'd0);
    check_eq("rst_drop", {24'd0, drop_cnt}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);

    // Single word, busy pulse E3..E12
    req0_data = 16'hA5C3; req0_valid = 1'b1; exp_q.push_back(16'hA5C3);
    tick();
    req0_valid = 1'b0;
    check_eq("single_ready_low", {31'd0, req0_ready}, 32'd0);
    tick();
    check_eq("single_stb_e1", {31'd0, tx_stb}, 32'd1);
    check_eq("single_grant", {30'd0, grant}, 32'd1);
    tick();
    check_eq("single_stb_e2", {31'd0, tx_stb}, 32'd0);
    xfer(1, 9);
    check_eq("single_ready_e12", {31'd0, req0_ready}, 32'd0);
    tick();
    check_eq("single_ready_e13", {31'd0, req0_ready}, 32'd1);
    check_eq("single_data_hold", {16'd0, tx_data}, 32'h0000A5C3);

    // Contention: same-cycle loads, req0 first both rounds
    for (int r = 0; r < 2; r++) begin
      req0_data = (r == 0) ? 16'h1111 : 16'h3333;
      req1_data = (r == 0) ? 16'h2222 : 16'h4444;
      req0_valid = 1'b1; req1_valid = 1'b1;
      exp_q.push_back(req0_data); exp_q.push_back(req1_data);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_stb(10);
      check_eq("cont_grant0", {30'd0, grant}, 32'd1);
      xfer(2, 3);
      wait_stb(10);
      check_eq("cont_grant1", {30'd0, grant}, 32'd2);
      xfer(2, 3);
      repeat (3) tick();
    end

    // Drops and busy-at-idle
    tx_busy = 1'b1;
    req1_data = 16'h0BEE; req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      req1_data = 16'hD000 + 16'(i);
      tick();
    end
    req1_valid = 1'b0;
    check_eq("drop_cnt3", {24'd0, drop_cnt}, 32'd3);
    check_eq("drop_ready1", {31'd0, req1_ready}, 32'd0);
    req0_data = 16'h0A0A; req0_valid = 1'b1;
    exp_q.push_back(16'h0A0A); exp_q.push_back(16'h0BEE);
    tick();
    req1_valid = 1'b1;
    tick();
    check_eq("drop_both_adds2", {24'd0, drop_cnt}, 32'd5);
    repeat (149) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("drop_saturate", {24'd0, drop_cnt}, 32'd255);
    check_eq("busy_idle_no_stb", {31'd0, tx_stb}, 32'd0);
    tx_busy = 1'b0;
    tick();
    check_eq("busy_idle_stb", {31'd0, tx_stb}, 32'd1);
    xfer(1, 2);
    wait_stb(10);
    xfer(1, 2);
    repeat (3) tick();

    // Contention after a reload while busy blocks IDLE
    req0_data = 16'h5555; req1_data = 16'h6666;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_q.push_back(16'h5555);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_stb(10);
    xfer(1, 3);
    tick();
    check_eq("rr_ready0_released", {31'd0, req0_ready}, 32'd1);
    tx_busy = 1'b1; req0_data = 16'h7777; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    check_eq("rr_no_stb_busy", {31'd0, tx_stb}, 32'd0);
`ifdef UART_ARB_RR_EN
    exp_q.push_back(16'h6666); exp_q.push_back(16'h7777);
`else
    exp_q.push_back(16'h7777); exp_q.push_back(16'h6666);
`endif
    tx_busy = 1'b0;
    wait_stb(10);
    xfer(1, 2);
    wait_stb(10);
    xfer(1, 2);
    repeat (3) tick();

    // Timeout: busy never rises
    req0_data = 16'h0DD5; req0_valid = 1'b1; exp_q.push_back(16'h0DD5);
    tick();
    req0_valid = 1'b0;
    tick();
    check_eq("to_stb_e1", {31'd0, tx_stb}, 32'd1);
    repeat (8) tick();
    check_eq("to_ready_e9", {31'd0, req0_ready}, 32'd0);
    check_eq("to_flag_e9", {31'd0, timeout}, 32'd0);
    tick();
    check_eq("to_flag_e10", {31'd0, timeout}, 32'd1);
    check_eq("to_ready_e10", {31'd0, req0_ready}, 32'd1);
    req0_data = 16'h1234; req0_valid = 1'b1; exp_q.push_back(16'h1234);
    tick();
    req0_valid = 1'b0;
    wait_stb(10);
    xfer(1, 2);
    repeat (3) tick();
    check_eq("to_sticky", {31'd0, timeout}, 32'd1);

    // Reset in WAIT_LO with the other buffer loaded
    req0_data = 16'hBEEF; req0_valid = 1'b1; exp_q.push_back(16'hBEEF);
    tick();
    req0_valid = 1'b0;
    wait_stb(10);
    req1_data = 16'hCAFE; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0; tx_busy = 1'b1;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_stb", {31'd0, tx_stb}, 32'd0);
    check_eq("arst_ready0", {31'd0, req0_ready}, 32'd1);
    check_eq("arst_ready1", {31'd0, req1_ready}, 32'd1);
    check_eq("arst_grant", {30'd0, grant}, 32'd0);
    check_eq("arst_drop", {24'd0, drop_cnt}, 32'd0);
    check_eq("arst_timeout", {31'd0, timeout}, 32'd0);
    check_eq("arst_data", {16'd0, tx_data}, 32'd0);
    tx_busy = 1'b0;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    req0_data = 16'h4321; req0_valid = 1'b1; exp_q.push_back(16'h4321);
    tick();
    req0_valid = 1'b0;
    wait_stb(10);
    xfer(1, 2);
    repeat (3) tick();

    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
